led_pulse_blinker: RTL and testbench

- Output-side counterpart of the button debouncer. Turns single-cycle event pulses into LED blink patterns that a person can see on a GPIO LED pin.
- Each accepted event produces BLINKS on/off blinks.
- Events that arrive while a pattern is playing are counted in a saturating pending counter and replayed in order.
- Sits between internal event sources (e.g. a debounced button pulse) and the board LED pin.

---
 rtl/led_pulse_blinker_pkg.sv | 8 +
 rtl/led_pulse_blinker_sat_event_counter.sv | 34 +++
 rtl/led_pulse_blinker.sv | 91 +++++++++
 tb/tb_led_pulse_blinker.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/led_pulse_blinker_pkg.sv
// led_pulse_blinker_pkg: shared FSM state type and board-level timing defaults
package led_pulse_blinker_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF} state_e;
  // Board timing for the 50 MHz clock, kept next to the button debouncer threshold
  localparam int ON_CYCLES_DEF  = 25000000;
  localparam int OFF_CYCLES_DEF = 25000000;
  localparam int DEB_CYCLES_DEF = 500000;
endpackage

// File: rtl/led_pulse_blinker_sat_event_counter.sv
// sat_event_counter: saturating up/down event counter with sticky overflow flag
module sat_event_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         ovf
);
  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d, sat, drop;
  always_comb begin
    sat     = &count_q;
    drop    = inc && !dec && sat;
    count_d = (inc && !dec && !sat) ? count_q + 1'b1 :
              (dec && !inc && count_q != '0) ? count_q - 1'b1 : count_q;
    // a drop in the same cycle as a clear must still be reported
    ovf_d   = drop || (ovf_q && !clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  assign count = count_q;
  assign ovf   = ovf_q;
endmodule

// File: rtl/led_pulse_blinker.sv
// led_pulse_blinker: plays BLINKS on/off blinks per event pulse, queueing events that arrive mid-pattern
module led_pulse_blinker
  import led_pulse_blinker_pkg::*;
#(
  parameter int ON_CYCLES  = ON_CYCLES_DEF,
  parameter int OFF_CYCLES = OFF_CYCLES_DEF,
  parameter int BLINKS     = 2,
  parameter int CNT_W      = 25,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              ovf_clr,
  output logic              gpio_led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);
  localparam int BW = (BLINKS > 1) ? $clog2(BLINKS) : 1;
  localparam logic [CNT_W-1:0] ON_TC  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_TC = CNT_W'(OFF_CYCLES - 1);
  localparam logic [BW-1:0]    BLK_LD = BW'(BLINKS - 1);
  state_e           state_q;
  logic [CNT_W-1:0] timer_q;
  logic [BW-1:0]    blink_q;
  logic             led_q, busy_q, tc, start;
  always_comb begin
    tc    = (state_q == ON) ? (timer_q == ON_TC) : (timer_q == OFF_TC);
    // a new event starts from IDLE, or straight out of the last gap of the previous event
    start = (pending != '0) && (state_q == IDLE || (state_q == OFF && tc && blink_q == '0));
  end
  sat_event_counter #(.W(PEND_W)) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pulse_in),
    .dec   (start),
    .clr   (ovf_clr),
    .count (pending),
    .ovf   (ovf)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      blink_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= ON;
          timer_q <= '0;
          blink_q <= BLK_LD;
          led_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
        ON: if (tc) begin
          state_q <= OFF;
          timer_q <= '0;
          led_q   <= 1'b0;
        end else timer_q <= timer_q + 1'b1;
        OFF: if (!tc) timer_q <= timer_q + 1'b1;
        else if (blink_q != '0) begin
          state_q <= ON;
          timer_q <= '0;
          blink_q <= blink_q - 1'b1;
          led_q   <= 1'b1;
        end else if (start) begin
          state_q <= ON;
          timer_q <= '0;
          blink_q <= BLK_LD;
          led_q   <= 1'b1;
        end else begin
          state_q <= IDLE;
          timer_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
          blink_q <= '0;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign gpio_led = led_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_led_pulse_blinker.sv
// tb_led_pulse_blinker: directed stimulus with a time-stamped expectation scoreboard
module tb_led_pulse_blinker;
  typedef struct {int at; int sel; int val;} exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse_in = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       gpio_led, busy, ovf;
  logic [1:0] pending;
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;
  int         base;
  exp_t       sb[$];

  led_pulse_blinker #(.ON_CYCLES(4), .OFF_CYCLES(3), .BLINKS(2), .CNT_W(3), .PEND_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .ovf_clr  (ovf_clr),
    .gpio_led (gpio_led),
    .busy     (busy),
    .pending  (pending),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic string nm(input int sel);
    return sel == 0 ? "led" : sel == 1 ? "busy" : sel == 2 ? "pending" : "ovf";
  endfunction

  task automatic push(input int at, input int sel, input int val);
    exp_t e;
    e.at = at;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    int a;
    a = e.sel == 0 ? int'(gpio_led) : e.sel == 1 ? int'(busy) : e.sel == 2 ? int'(pending) : int'(ovf);
    checks++;
    if (a != e.val) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm(e.sel), e.at, a, e.val);
    end
  endtask

  // clocked monitor: compare everything due after the current edge
  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at == edge_n) begin
        check(sb[i]);
        sb.delete(i);
      end

  // reset monitor: entries tagged -1 are due just after rst_n falls, no clock involved
  always @(negedge rst_n) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at < 0) begin
        check(sb[i]);
        sb.delete(i);
      end
  end

  // n back-to-back events whose first blink lights after edge b+s, then 3 idle edges
  task automatic exp_events(input int b, input int s, input int n);
    for (int o = 0; o < 14 * n + 3; o++) begin
      push(b + s + o, 0, (o < 14 * n && (o % 14 < 4 || (o % 14 >= 7 && o % 14 < 11))) ? 1 : 0);
      push(b + s + o, 1, o < 14 * n ? 1 : 0);
    end
  endtask

  task automatic drive(input logic [63:0] pm, input logic [63:0] cm, input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = pm[i];
      ovf_clr  = cm[i];
      @(negedge clk);
    end
    pulse_in = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (edge_n < t) @(negedge clk);
  endtask

  task automatic exp_quiet(input int b, input int n);
    for (int k = 0; k < n; k++)
      for (int s = 0; s < 4; s++) push(b + k, s, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    pulse_in = 1'b1;
    exp_quiet(edge_n + 1, 2);
    repeat (2) @(negedge clk);
    pulse_in = 1'b0;
    rst_n = 1'b1;
    // idle hold
    base = edge_n + 1;
    exp_quiet(base, 100);
    wait_until(base + 99);
    // single pulse
    base = edge_n + 1;
    push(base, 2, 1);
    push(base + 1, 2, 0);
    push(base, 0, 0);
    exp_events(base, 1, 1);
    drive(64'h1, 64'h0, 1);
    wait_until(base + 17);
    // burst during playback with overflow
    base = edge_n + 1;
    push(base, 2, 1); push(base + 1, 2, 0); push(base + 3, 2, 1); push(base + 5, 2, 2);
    push(base + 7, 2, 3); push(base + 8, 3, 0); push(base + 9, 2, 3); push(base + 9, 3, 1);
    push(base + 15, 2, 2); push(base + 29, 2, 1); push(base + 43, 2, 0); push(base + 50, 3, 1);
    exp_events(base, 1, 4);
    drive(64'h2A9, 64'h0, 10);
    wait_until(base + 59);
    // pulse on the same edge the FSM leaves IDLE
    base = edge_n + 1;
    push(base, 2, 1); push(base + 1, 2, 1); push(base + 2, 3, 1); push(base + 15, 2, 0);
    exp_events(base, 1, 2);
    drive(64'h3, 64'h0, 2);
    wait_until(base + 31);
    // ovf_clr alone, then clear racing an overflow, then clear alone
    base = edge_n + 1;
    push(base, 3, 0); push(base, 2, 0);
    drive(64'h0, 64'h1, 1);
    base = edge_n + 1;
    push(base, 2, 1); push(base + 1, 2, 0); push(base + 2, 2, 1); push(base + 3, 2, 2);
    push(base + 4, 2, 3); push(base + 5, 2, 3); push(base + 5, 3, 1);
    push(base + 6, 2, 3); push(base + 6, 3, 0);
    exp_events(base, 1, 4);
    drive(64'h3D, 64'h60, 7);
    wait_until(base + 59);
    // async reset mid-ON with two events queued
    base = edge_n + 1;
    push(base + 3, 2, 2); push(base + 3, 0, 1); push(base + 3, 1, 1);
    drive(64'hD, 64'h0, 4);
    for (int s = 0; s < 4; s++) push(-1, s, 0);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = edge_n + 1;
    exp_quiet(base, 20);
    wait_until(base + 19);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
